bin2bcd_disp: RTL and testbench
===============================

// Module: bin2bcd_disp
// PURPOSE
//  Sequential double-dabble binary-to-BCD converter. It feeds the 4-digit 7-segment
//  display driver: data[15:0] carries 4 BCD nibbles, en[3:0] is the per-digit enable, dot[3:0] is per-digit.
//  It accepts a binary value on a start pulse and converts it over BIN_WIDTH shift cycles.
//  Display outputs update atomically on completion, so the display never shows a partial result.
// PARAMETERS
//  BIN_WIDTH  14  width of binary input; one shift cycle per bit
//  DIGITS      4  BCD digits produced; data width = 4*DIGITS; max displayable = 10^DIGITS-1
// PORTS
//  clk    in   1           main clock
//  rst    in   1           reset, asynchronous, active-high
//  start  in   1           conversion request; sampled only in IDLE
//  value  in   BIN_WIDTH   unsigned binary to convert; captured on accepted start
//  dot_in in   DIGITS      dot pattern; captured with value
//  busy   out  1           conversion in progress
//  done   out  1           one-cycle pulse: data/en/dot/ovf just updated
//  ovf    out  1           last captured value > 10^DIGITS-1
//  data   out  4*DIGITS    BCD result, digit 0 in [3:0]
//  en     out  DIGITS      digit enables for display
//  dot    out  DIGITS      dot enables for display
// BEHAVIOUR
//  - All outputs are registered. Reset values: busy=0, done=0, ovf=0, data=0, dot=0.
//    en resets to 1 on digit 0 only with blanking compiled in; otherwise en resets to all ones.
//  - FSM states: IDLE, SHIFT, FINISH.
//    IDLE->SHIFT when start=1.
//    SHIFT->FINISH after exactly BIN_WIDTH shift cycles, tracked by a bit counter.
//    FINISH->IDLE unconditionally.
//  - Edge E0 (IDLE, start=1): capture value into the shift register and dot_in into a dot holding register.
//    Also clear the BCD accumulator, set busy=1, and compute the overflow flag (value >= 10^DIGITS).
//  - Each SHIFT cycle: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
//    Adjust and shift happen in the same cycle.
//  - Edge E0+BIN_WIDTH+1 (FINISH): write data/en/dot/ovf, set done=1 for exactly one cycle, clear busy.
//    With defaults, done is high during the 16th cycle after start was sampled.
//  - Latency is fixed at BIN_WIDTH+1 cycles regardless of value, including overflow.
//  - Overflow: data = all 4'hF nibbles, en = all ones, ovf=1; dot comes from the holding register.
//  - start while busy (SHIFT/FINISH) is ignored and not queued. start in the cycle done is high
//    (state IDLE) is accepted.
//  - data/en/dot/ovf hold their previous values throughout a conversion.
//  - Reset mid-conversion aborts the conversion: return to IDLE and apply the reset output values.
//    No done pulse is produced.
//  - Value 0 gives data=0. Max in-range value 10^DIGITS-1 gives all 4'h9 nibbles.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    en[i]=0 for each leading zero digit above the most significant nonzero digit.
//    en[0] is always 1, so 0 displays as a single "0".
//    On overflow en = all ones.
//  LEADING_ZERO_BLANK_EN undefined: en = all ones after every conversion and after reset.
// TESTING
//  - value=1234, start 1 cycle -> busy for 15 cycles; done in cycle 16; data=16'h1234, ovf=0.
//  - value=7 -> data=16'h0007; en=4'b0001 with LEADING_ZERO_BLANK_EN, 4'b1111 without.
//  - value=0 -> data=0, en=4'b0001 (blank on). value=9999 -> data=16'h9999, en=4'b1111.
//  - value=10000 and value=16383 -> ovf=1, data=16'hFFFF, en=4'b1111, latency still 16 cycles.
//  - start=1 held 20 cycles with value=42 then 99 -> first result 16'h0042.
//    Accepted again in the done cycle; second result per the value sampled then. Exactly two done pulses.
//  - rst pulsed at cycle 7 of a conversion -> all outputs at reset values immediately (async), no done.
//    Next start converts correctly.

Source files
------------

// File: rtl/bin2bcd_disp.sv
// Sequential double-dabble binary-to-BCD converter feeding a 7-segment driver.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bin2bcd_disp #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  value,
  input  logic [DIGITS-1:0]     dot_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   data,
  output logic [DIGITS-1:0]     en,
  output logic [DIGITS-1:0]     dot
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int unsigned LIMIT = 10 ** DIGITS;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [DIGITS-1:0] EN_RST = DIGITS'(1);
`else
  localparam logic [DIGITS-1:0] EN_RST = '1;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0]  bin_q, bin_d;
  logic [DW-1:0]         bcd_q, bcd_d;
  logic [DIGITS-1:0]     dotr_q, dotr_d;
  logic                  ovfp_q, ovfp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [DW-1:0]         data_q, data_d;
  logic [DIGITS-1:0]     en_q, en_d;
  logic [DIGITS-1:0]     dot_q, dot_d;

  logic [DW-1:0]         bcd_adj;
  logic [DW-1:0]         bcd_sh;
  logic [BIN_WIDTH-1:0]  bin_sh;
  logic [DIGITS-1:0]     en_calc;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[DW-2:0], bin_q[BIN_WIDTH-1]};
    bin_sh = {bin_q[BIN_WIDTH-2:0], 1'b0};
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  // Blank zero digits above the most significant nonzero one; digit 0 always lit
  always_comb begin
    en_calc = '1;
    lead    = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && bcd_q[4*i +: 4] == 4'd0)
        en_calc[i] = 1'b0;
      else
        lead = 1'b0;
    end
  end
`else
  always_comb en_calc = '1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    dotr_d  = dotr_q;
    ovfp_d  = ovfp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    data_d  = data_q;
    en_d    = en_q;
    dot_d   = dot_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          bin_d   = value;
          dotr_d  = dot_in;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          ovfp_d  = 32'(value) >= LIMIT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_WIDTH - 1))
          state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ovf_d   = ovfp_q;
        dot_d   = dotr_q;
        if (ovfp_q) begin
          data_d = '1;
          en_d   = '1;
        end else begin
          data_d = bcd_q;
          en_d   = en_calc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      dotr_q  <= '0;
      ovfp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      en_q    <= EN_RST;
      dot_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      dotr_q  <= dotr_d;
      ovfp_q  <= ovfp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      en_q    <= en_d;
      dot_q   <= dot_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign data = data_q;
  assign en   = en_q;
  assign dot  = dot_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Scoreboard bench for bin2bcd_disp: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_bin2bcd_disp;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] value;
  logic [3:0]  dot_in;
  logic        busy, done, ovf;
  logic [15:0] data;
  logic [3:0]  en, dot;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  dot;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          cyc = 0;
  int          pass = 0;
  int          total = 0;
  logic [15:0] last_data;

  bin2bcd_disp #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .dot_in(dot_in), .busy(busy), .done(done), .ovf(ovf),
    .data(data), .en(en), .dot(dot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)", cyc);
      end else begin
        me = sb.pop_front();
        chk("data", data, me.data);
        chk("en", en, me.en);
        chk("dot", dot, me.dot);
        chk("ovf", ovf, me.ovf);
        chk("latency", cyc, me.cyc);
        chk("busy_clr", busy, 0);
      end
    end
  end

  task automatic drain(input int n);
    for (int i = 0; i < n && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic conv(input logic [13:0] v, input logic [3:0] d,
                      input logic [15:0] ed, input logic [3:0] eb,
                      input bit eo);
    exp_t e;
    @(negedge clk);
    value  = v;
    dot_in = d;
    start  = 1'b1;
    e.data = ed;
    e.en   = BLANK ? eb : 4'hF;
    e.dot  = d;
    e.ovf  = eo;
    e.cyc  = cyc + 16;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_set", busy, 1);
    chk("data_hold", data, last_data);
    drain(40);
    last_data = ed;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; value = '0; dot_in = '0;
    last_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", data, 0);
    chk("rst_dot", dot, 0);
    chk("rst_en", en, BLANK ? 4'b0001 : 4'b1111);
    rst = 1'b0;

    conv(14'd1234, 4'b0010, 16'h1234, 4'b1111, 1'b0);
    conv(14'd7,    4'b0001, 16'h0007, 4'b0001, 1'b0);
    conv(14'd0,    4'b0000, 16'h0000, 4'b0001, 1'b0);
    conv(14'd9999, 4'b1000, 16'h9999, 4'b1111, 1'b0);
    conv(14'd10000, 4'b0100, 16'hFFFF, 4'b1111, 1'b1);
    conv(14'd305,  4'b0000, 16'h0305, 4'b0111, 1'b0);
    conv(14'd16383, 4'b0101, 16'hFFFF, 4'b1111, 1'b1);

    // Held start: 42 accepted first, 99 accepted again in the done cycle
    @(negedge clk);
    value = 14'd42; dot_in = 4'b0000; start = 1'b1;
    e.data = 16'h0042; e.en = BLANK ? 4'b0011 : 4'hF;
    e.dot = 4'b0000; e.ovf = 1'b0; e.cyc = cyc + 16;
    sb.push_back(e);
    e.data = 16'h0099; e.cyc = cyc + 32;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    value = 14'd99;
    repeat (18) @(negedge clk);
    start = 1'b0;
    drain(40);
    repeat (3) @(negedge clk);

    // Reset in the middle of a conversion
    @(negedge clk);
    value = 14'd1234; dot_in = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_data", data, 0);
    chk("arst_dot", dot, 0);
    chk("arst_en", en, BLANK ? 4'b0001 : 4'b1111);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_data = '0;
    repeat (25) @(negedge clk);

    conv(14'd305, 4'b0011, 16'h0305, 4'b0111, 1'b0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
